tour_cmd_seq: RTL and testbench

- Sequencer between the knight's-tour solver and the command processor.
- When idle, it passes UART commands straight through to the command processor.
- On start_tour, it takes over the command path and steps the solver's move index 0..23.
- Each stored one-hot move becomes two movement commands (vertical leg, then horizontal leg), each sent with a cmd_rdy/clr_cmd_rdy handshake and completed on send_resp.

---
 rtl/tour_pkg.sv | 30 +++
 rtl/tour_cmd_seq_move_decode.sv | 38 +++
 rtl/tour_cmd_seq.sv | 110 +++++++++++
 tb/tb_tour_cmd_seq.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tour_pkg.sv
// Shared types and constants for the knight's-tour command sequencer.
package tour_pkg;

  localparam int unsigned NUM_MOVES = 24;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned CMD_W     = 16;
  localparam int unsigned RESP_W    = 8;
  localparam int unsigned MOVE_W    = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    VERT   = 3'd1,
    WAIT_V = 3'd2,
    HORZ   = 3'd3,
    WAIT_H = 3'd4
  } state_e;

  localparam logic [3:0] MOVE         = 4'h2;
  localparam logic [3:0] MOVE_FANFARE = 4'h3;

  localparam logic [7:0] NORTH = 8'h00;
  localparam logic [7:0] WEST  = 8'h3F;
  localparam logic [7:0] SOUTH = 8'h7F;
  localparam logic [7:0] EAST  = 8'hBF;

  localparam logic [RESP_W-1:0] RESP_DONE = 8'hA5;
  localparam logic [RESP_W-1:0] RESP_POS  = 8'h5A;
  localparam logic [RESP_W-1:0] RESP_ERR  = 8'hEE;

endpackage

// File: rtl/tour_cmd_seq_move_decode.sv
// One-hot knight move -> vertical/horizontal movement commands.
module move_decode
  import tour_pkg::*;
(
  input  logic [MOVE_W-1:0] move,
  output logic [CMD_W-1:0]  vert_cmd,
  output logic [CMD_W-1:0]  horz_cmd,
  output logic              illegal
);

  logic       north;
  logic       east;
  logic [3:0] v_sq;
  logic [3:0] h_sq;

  always_comb begin
    north   = 1'b0;
    east    = 1'b0;
    v_sq    = 4'd0;
    h_sq    = 4'd0;
    illegal = 1'b0;
    unique case (move)
      8'h01: begin north = 1'b1; v_sq = 4'd1; east = 1'b1; h_sq = 4'd2; end
      8'h02: begin north = 1'b1; v_sq = 4'd2; east = 1'b1; h_sq = 4'd1; end
      8'h04: begin north = 1'b1; v_sq = 4'd2; east = 1'b0; h_sq = 4'd1; end
      8'h08: begin north = 1'b1; v_sq = 4'd1; east = 1'b0; h_sq = 4'd2; end
      8'h10: begin north = 1'b0; v_sq = 4'd1; east = 1'b0; h_sq = 4'd2; end
      8'h20: begin north = 1'b0; v_sq = 4'd2; east = 1'b0; h_sq = 4'd1; end
      8'h40: begin north = 1'b0; v_sq = 4'd2; east = 1'b1; h_sq = 4'd1; end
      8'h80: begin north = 1'b0; v_sq = 4'd1; east = 1'b1; h_sq = 4'd2; end
      default: illegal = 1'b1;
    endcase
  end

  assign vert_cmd = {MOVE, north ? NORTH : SOUTH, v_sq};
  assign horz_cmd = {MOVE_FANFARE, east ? EAST : WEST, h_sq};

endmodule

// File: rtl/tour_cmd_seq.sv
// Replays a solved knight's tour as movement commands; passes UART commands through when idle.
module tour_cmd_seq
  import tour_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_tour,
  input  logic [MOVE_W-1:0]  move,
  output logic [IDX_W-1:0]   mv_indx,
  input  logic [CMD_W-1:0]   cmd_UART,
  input  logic               cmd_rdy_UART,
  output logic               clr_cmd_rdy_UART,
  output logic [CMD_W-1:0]   cmd,
  output logic               cmd_rdy,
  input  logic               clr_cmd_rdy,
  input  logic               send_resp,
  output logic [RESP_W-1:0]  resp
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    mv_indx_q, mv_indx_d;
  logic [MOVE_W-1:0]   move_q, move_d;
  logic [MOVE_W-1:0]   dec_move;
  logic [CMD_W-1:0]    vert_cmd;
  logic [CMD_W-1:0]    horz_cmd;
  logic                illegal;
  logic                last_move;

  // Live move while in VERT (mv_indx already settled); the captured copy afterwards.
  assign dec_move  = (state_q == VERT) ? move : move_q;
  assign last_move = (mv_indx_q == IDX_W'(NUM_MOVES - 1));
  assign mv_indx   = mv_indx_q;

  move_decode u_move_decode (
    .move     (dec_move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd),
    .illegal  (illegal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mv_indx_q <= '0;
      move_q    <= '0;
    end else begin
      state_q   <= state_d;
      mv_indx_q <= mv_indx_d;
      move_q    <= move_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    mv_indx_d        = mv_indx_q;
    move_d           = move_q;
    cmd              = cmd_UART;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    unique case (state_q)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_DONE;
        if (start_tour) begin
          mv_indx_d = '0;
          state_d   = VERT;
        end
      end
      VERT: begin
        cmd    = vert_cmd;
        move_d = move;
        if (illegal) begin
          resp      = RESP_ERR;
          mv_indx_d = '0;
          state_d   = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy) state_d = WAIT_V;
        end
      end
      WAIT_V: begin
        cmd = vert_cmd;
        if (send_resp) state_d = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy) state_d = WAIT_H;
      end
      WAIT_H: begin
        cmd  = horz_cmd;
        resp = last_move ? RESP_DONE : RESP_POS;
        if (send_resp) begin
          if (last_move) begin
            mv_indx_d = '0;
            state_d   = IDLE;
          end else begin
            mv_indx_d = mv_indx_q + IDX_W'(1);
            state_d   = VERT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tour_cmd_seq.sv
// Bench for tour_cmd_seq: vector tables, directed corner sequences, random full tour vs. a move model.
module tb_tour_cmd_seq;

  localparam int unsigned NMOV = 24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_tour;
  logic [7:0]  move;
  logic [4:0]  mv_indx;
  logic [15:0] cmd_UART;
  logic        cmd_rdy_UART;
  logic        clr_cmd_rdy_UART;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        send_resp;
  logic [7:0]  resp;

  logic        use_tour;
  logic [7:0]  move_man;
  logic [7:0]  tour [32];

  int checks = 0;
  int errors = 0;
  int ncmds  = 0;

  always #5 clk = ~clk;

  // Solver stand-in: either a stored tour indexed by mv_indx or a directly driven move.
  assign move = use_tour ? tour[mv_indx] : move_man;

  tour_cmd_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_tour       (start_tour),
    .move             (move),
    .mv_indx          (mv_indx),
    .cmd_UART         (cmd_UART),
    .cmd_rdy_UART     (cmd_rdy_UART),
    .clr_cmd_rdy_UART (clr_cmd_rdy_UART),
    .cmd              (cmd),
    .cmd_rdy          (cmd_rdy),
    .clr_cmd_rdy      (clr_cmd_rdy),
    .send_resp        (send_resp),
    .resp             (resp)
  );

  typedef struct {
    logic [15:0] c_uart;
    logic        rdy_uart;
    logic        clr;
    logic [15:0] e_cmd;
    logic        e_rdy;
    logic        e_clr_uart;
    logic [7:0]  e_resp;
  } idle_vec_t;

  typedef struct {
    logic [7:0]  mv;
    logic [15:0] e_v;
    logic [15:0] e_h;
  } move_vec_t;

  idle_vec_t idle_tab [4];
  move_vec_t move_tab [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: knight offsets from the move bit, then heading/magnitude per leg.
  function automatic logic [31:0] model_cmds(input logic [7:0] mv);
    int dx [8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    int dy [8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    int k = 0;
    logic [15:0] v, h;
    for (int b = 0; b < 8; b++) if (mv[b]) k = b;
    v = {4'h2, (dy[k] > 0) ? 8'h00 : 8'h7F, 4'((dy[k] > 0) ? dy[k] : -dy[k])};
    h = {4'h3, (dx[k] > 0) ? 8'hBF : 8'h3F, 4'((dx[k] > 0) ? dx[k] : -dx[k])};
    return {v, h};
  endfunction

  task automatic wait_rdy(input string name, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (cmd_rdy === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s: cmd_rdy timeout got 0 expected 1 at %0t", name, $time);
    end
  endtask

  // One full move: vertical leg, intermediate response, horizontal leg, final response.
  task automatic run_move(input logic [7:0] mv, input logic [15:0] ev, input logic [15:0] eh,
                          input int idx, input bit last, input bit scramble);
    bit ok;
    move_man = mv;
    wait_rdy("vert_rdy", ok);
    if (!ok) return;
    chk("vert_cmd", 32'(cmd), 32'(ev));
    chk("vert_idx", 32'(mv_indx), 32'(idx));
    repeat ($urandom_range(0, 2)) @(negedge clk);
    clr_cmd_rdy = 1'b1;
    send_resp   = 1'($urandom_range(0, 1));
    @(negedge clk);
    clr_cmd_rdy = 1'b0; send_resp = 1'b0;
    if (scramble) move_man = 8'($urandom);
    #1;
    chk("waitv_rdy", 32'(cmd_rdy), 32'd0);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_resp = 1'b1; #1;
    chk("resp_pos", 32'(resp), 32'h5A);
    @(negedge clk);
    send_resp = 1'b0;
    ncmds++;
    wait_rdy("horz_rdy", ok);
    if (!ok) return;
    chk("horz_cmd", 32'(cmd), 32'(eh));
    chk("horz_idx", 32'(mv_indx), 32'(idx));
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_resp = 1'b1; #1;
    chk("resp_final", 32'(resp), last ? 32'hA5 : 32'h5A);
    @(negedge clk);
    send_resp = 1'b0; #1;
    ncmds++;
    chk("idx_next", 32'(mv_indx), last ? 32'd0 : 32'(idx + 1));
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_tour = 1'b1;
    @(negedge clk);
    start_tour = 1'b0;
  endtask

  initial begin
    bit ok;
    logic [31:0] m;
    idle_tab[0] = '{16'h2004, 1'b1, 1'b0, 16'h2004, 1'b1, 1'b0, 8'hA5};
    idle_tab[1] = '{16'h2004, 1'b1, 1'b1, 16'h2004, 1'b1, 1'b1, 8'hA5};
    idle_tab[2] = '{16'hBEEF, 1'b0, 1'b1, 16'hBEEF, 1'b0, 1'b1, 8'hA5};
    idle_tab[3] = '{16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 8'hA5};
    move_tab[0] = '{8'h01, 16'h2001, 16'h3BF2};
    move_tab[1] = '{8'h20, 16'h27F2, 16'h33F1};
    move_tab[2] = '{8'h80, 16'h27F1, 16'h3BF2};
    move_tab[3] = '{8'h02, 16'h2002, 16'h3BF1};
    move_tab[4] = '{8'h08, 16'h2001, 16'h33F2};
    move_tab[5] = '{8'h10, 16'h27F1, 16'h33F2};
    move_tab[6] = '{8'h40, 16'h27F2, 16'h3BF1};
    move_tab[7] = '{8'h04, 16'h2002, 16'h33F1};

    rst_n = 1'b0; start_tour = 1'b0; cmd_UART = 16'h0000; cmd_rdy_UART = 1'b0;
    clr_cmd_rdy = 1'b0; send_resp = 1'b0; use_tour = 1'b0; move_man = 8'h01;
    for (int i = 0; i < 32; i++) tour[i] = 8'h01;
    #1;
    chk("rst_idx", 32'(mv_indx), 32'd0);
    chk("rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("rst_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    chk("rst_resp", 32'(resp), 32'hA5);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle pass-through vectors
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      cmd_UART = idle_tab[i].c_uart; cmd_rdy_UART = idle_tab[i].rdy_uart;
      clr_cmd_rdy = idle_tab[i].clr; #1;
      chk("idle_cmd", 32'(cmd), 32'(idle_tab[i].e_cmd));
      chk("idle_rdy", 32'(cmd_rdy), 32'(idle_tab[i].e_rdy));
      chk("idle_clr_uart", 32'(clr_cmd_rdy_UART), 32'(idle_tab[i].e_clr_uart));
      chk("idle_resp", 32'(resp), 32'(idle_tab[i].e_resp));
    end
    @(negedge clk);
    cmd_rdy_UART = 1'b0; clr_cmd_rdy = 1'b0;

    // Moves 0..4 from the table, then an illegal move at index 5
    move_man = move_tab[0].mv;
    pulse_start();
    for (int i = 0; i < 5; i++)
      run_move(move_tab[i].mv, move_tab[i].e_v, move_tab[i].e_h, i, 1'b0, 1'b1);
    move_man = 8'h03; #1;
    chk("illegal_idx", 32'(mv_indx), 32'd5);
    chk("illegal_rdy", 32'(cmd_rdy), 32'd0);
    chk("illegal_resp", 32'(resp), 32'hEE);
    @(negedge clk); #1;
    chk("illegal_idle_idx", 32'(mv_indx), 32'd0);
    chk("illegal_idle_resp", 32'(resp), 32'hA5);
    chk("illegal_idle_rdy", 32'(cmd_rdy), 32'd0);
    chk("illegal_idle_cmd", 32'(cmd), 32'(cmd_UART));

    // Remaining table moves, then mid-tour robustness while waiting on a vertical leg
    move_man = move_tab[5].mv;
    pulse_start();
    for (int i = 5; i < 8; i++)
      run_move(move_tab[i].mv, move_tab[i].e_v, move_tab[i].e_h, i - 5, 1'b0, 1'b0);
    move_man = 8'h40;
    wait_rdy("mid_rdy", ok);
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b1; cmd_rdy_UART = 1'b1; start_tour = 1'b1; cmd_UART = 16'h2004; #1;
    chk("mid_clr_uart", 32'(clr_cmd_rdy_UART), 32'd0);
    chk("mid_rdy_blocked", 32'(cmd_rdy), 32'd0);
    @(negedge clk);
    start_tour = 1'b0; clr_cmd_rdy = 1'b0; #1;
    chk("mid_idx", 32'(mv_indx), 32'd3);
    chk("mid_cmd_held", 32'(cmd), 32'h27F2);
    chk("mid_rdy_still", 32'(cmd_rdy), 32'd0);
    cmd_rdy_UART = 1'b0; rst_n = 1'b0; #1;
    chk("mid_rst_idx", 32'(mv_indx), 32'd0);
    chk("mid_rst_rdy", 32'(cmd_rdy), 32'd0);
    chk("mid_rst_cmd", 32'(cmd), 32'h2004);
    @(negedge clk);
    rst_n = 1'b1; cmd_rdy_UART = 1'b1; #1;
    chk("post_rst_pass", 32'(cmd_rdy), 32'd1);
    @(negedge clk);
    cmd_rdy_UART = 1'b0;

    // Full random tour checked against the offset model
    for (int i = 0; i < NMOV; i++) tour[i] = 8'(1 << $urandom_range(0, 7));
    use_tour = 1'b1;
    ncmds = 0;
    pulse_start();
    for (int i = 0; i < NMOV; i++) begin
      m = model_cmds(tour[i]);
      run_move(8'h00, m[31:16], m[15:0], i, i == NMOV - 1, 1'b0);
    end
    @(negedge clk); #1;
    chk("tour_ncmds", 32'(ncmds), 32'd48);
    chk("tour_end_idx", 32'(mv_indx), 32'd0);
    chk("tour_end_resp", 32'(resp), 32'hA5);
    chk("tour_end_rdy", 32'(cmd_rdy), 32'd0);
    chk("tour_end_cmd", 32'(cmd), 32'(cmd_UART));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
